// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Definitions shared by the systolic array and its tile controller:
//   - ctrl_state_t : tile controller FSM states
//   - DEF_*        : default array geometry and bus widths
//   - sat_inc32    : saturating increment for 32-bit performance counters
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int unsigned DEF_ROWS       = 32'd64;
    localparam int unsigned DEF_COLS       = 32'd64;
    localparam int unsigned DEF_IP_WIDTH   = 32'd8;
    localparam int unsigned DEF_K_WIDTH    = 32'd16;
    localparam int unsigned DEF_ADDR_WIDTH = 32'd16;

    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } ctrl_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == PERF_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/operand_addr_gen.sv
// -----------------------------------------------------------------------------
// operand_addr_gen
// Beat counter plus A/W operand address counters for one tile.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load              : latch K and both base addresses (start of a tile)
//   step              : advance to the next beat (addresses + 1)
//   k                 : tile depth, must be non-zero when load is asserted
//   a_base, w_base    : first operand addresses
//   a_addr, w_addr    : current read addresses (registered)
//   last_beat         : current beat is beat K-1
// Addresses wrap modulo 2^addr_width; wrap-around is a legal access pattern.
// -----------------------------------------------------------------------------
module operand_addr_gen #(
    parameter int k_width    = 16,
    parameter int addr_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [k_width-1:0]    k,
    input  logic [addr_width-1:0] a_base,
    input  logic [addr_width-1:0] w_base,
    output logic [addr_width-1:0] a_addr,
    output logic [addr_width-1:0] w_addr,
    output logic                  last_beat
);

    logic [k_width-1:0]    beat_cnt_r;
    logic [k_width-1:0]    k_last_r;
    logic [addr_width-1:0] a_addr_r;
    logic [addr_width-1:0] w_addr_r;

    // Beat and address counters: load at tile start, advance once per issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= {k_width{1'b0}};
            k_last_r   <= {k_width{1'b0}};
            a_addr_r   <= {addr_width{1'b0}};
            w_addr_r   <= {addr_width{1'b0}};
        end else if (load) begin
            beat_cnt_r <= {k_width{1'b0}};
            // Storing K-1 keeps the last-beat compare a plain equality.
            k_last_r   <= k - k_width'(1);
            a_addr_r   <= a_base;
            w_addr_r   <= w_base;
        end else if (step) begin
            beat_cnt_r <= beat_cnt_r + k_width'(1);
            k_last_r   <= k_last_r;
            a_addr_r   <= a_addr_r + addr_width'(1);
            w_addr_r   <= w_addr_r + addr_width'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
            k_last_r   <= k_last_r;
            a_addr_r   <= a_addr_r;
            w_addr_r   <= w_addr_r;
        end
    end

    assign last_beat = (beat_cnt_r == k_last_r);
    assign a_addr    = a_addr_r;
    assign w_addr    = w_addr_r;

endmodule

// File: rtl/systolic_tile_controller.sv
// -----------------------------------------------------------------------------
// systolic_tile_controller
// Drives one systolic_array through a single output-stationary tile:
// accepts a tile command, streams K operand vectors from the A and W buffers
// (1-cycle read latency) into the array with en/clr framing, waits for the
// array's compute_done and offers the result through a valid/ready handshake.
// The array must be reset by the same rst as this controller.
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   start_valid/start_ready           : tile command handshake
//   start_k, start_a_base, start_w_base : tile depth and first operand addresses
//   a_rd_en/a_rd_addr/a_rd_data       : A operand buffer read port
//   w_rd_en/w_rd_addr/w_rd_data       : W operand buffer read port
//   sa_en, sa_clr                     : array enable / accumulator clear
//   sa_input_matrix, sa_weight_matrix : array operands (zero when sa_en=0)
//   sa_compute_done                   : array completion flag
//   res_valid/res_ready               : result-available handshake
//   busy                              : controller not idle
//   err_zero_k                        : one-cycle pulse on a K=0 command
//   perf_tiles, perf_busy_cycles      : performance counters
//
// Build option: define SYSTOLIC_CTRL_PERF_EN to implement the performance
// counters; otherwise both counter ports read zero.
// -----------------------------------------------------------------------------
module systolic_tile_controller
    import systolic_pkg::*;
#(
    parameter int rows       = 64,
    parameter int cols       = 64,
    parameter int ip_width   = 8,
    parameter int k_width    = 16,
    parameter int addr_width = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [k_width-1:0]       start_k,
    input  logic [addr_width-1:0]    start_a_base,
    input  logic [addr_width-1:0]    start_w_base,
    output logic                     a_rd_en,
    output logic [addr_width-1:0]    a_rd_addr,
    input  logic [rows*ip_width-1:0] a_rd_data,
    output logic                     w_rd_en,
    output logic [addr_width-1:0]    w_rd_addr,
    input  logic [cols*ip_width-1:0] w_rd_data,
    output logic                     sa_en,
    output logic                     sa_clr,
    output logic [rows*ip_width-1:0] sa_input_matrix,
    output logic [cols*ip_width-1:0] sa_weight_matrix,
    input  logic                     sa_compute_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     err_zero_k,
    output logic [31:0]              perf_tiles,
    output logic [31:0]              perf_busy_cycles
);

    ctrl_state_t state_r;
    ctrl_state_t state_nxt_s;

    logic start_ready_r;
    logic rd_en_r;
    logic sa_en_r;
    logic sa_clr_r;
    logic res_valid_r;
    logic busy_r;
    logic err_zero_k_r;

    logic accept_s;
    logic k_zero_s;
    logic load_s;
    logic step_s;
    logic last_beat_s;
    logic handshake_s;

    assign accept_s    = start_valid && (state_r == ST_IDLE);
    assign k_zero_s    = (start_k == {k_width{1'b0}});
    assign load_s      = accept_s && !k_zero_s;
    assign step_s      = rd_en_r && !last_beat_s;
    assign handshake_s = (state_r == ST_RESULT) && res_ready;

    operand_addr_gen #(
        .k_width    (k_width),
        .addr_width (addr_width)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .k         (start_k),
        .a_base    (start_a_base),
        .w_base    (start_w_base),
        .a_addr    (a_rd_addr),
        .w_addr    (w_rd_addr),
        .last_beat (last_beat_s)
    );

    // Next-state decode for the tile sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // The final sa_en beat is the one with no read outstanding behind it.
                if (sa_en_r && !rd_en_r) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_WAIT: begin
                if (sa_compute_done) begin
                    state_nxt_s = ST_RESULT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and all registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            start_ready_r <= 1'b1;
            rd_en_r       <= 1'b0;
            sa_en_r       <= 1'b0;
            sa_clr_r      <= 1'b0;
            res_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            err_zero_k_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            start_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            res_valid_r   <= (state_nxt_s == ST_RESULT);
            err_zero_k_r  <= accept_s && k_zero_s;

            if (load_s) begin
                rd_en_r <= 1'b1;
            end else if (rd_en_r && last_beat_s) begin
                rd_en_r <= 1'b0;
            end else begin
                rd_en_r <= rd_en_r;
            end

            // Read data returns one cycle after issue, so the array enable trails the read.
            sa_en_r  <= rd_en_r;
            // Reads are contiguous within a tile, so the first read is the only one
            // issued while sa_en is still low.
            sa_clr_r <= rd_en_r && !sa_en_r;
        end
    end

    assign start_ready      = start_ready_r;
    assign a_rd_en          = rd_en_r;
    assign w_rd_en          = rd_en_r;
    assign sa_en            = sa_en_r;
    assign sa_clr           = sa_clr_r;
    assign res_valid        = res_valid_r;
    assign busy             = busy_r;
    assign err_zero_k       = err_zero_k_r;
    assign sa_input_matrix  = sa_en_r ? a_rd_data : {(rows*ip_width){1'b0}};
    assign sa_weight_matrix = sa_en_r ? w_rd_data : {(cols*ip_width){1'b0}};

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_tiles_r;
    logic [31:0] perf_busy_r;

    // Saturating tile and busy-cycle counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_tiles_r <= 32'd0;
            perf_busy_r  <= 32'd0;
        end else begin
            if (handshake_s) begin
                perf_tiles_r <= sat_inc32(perf_tiles_r);
            end else begin
                perf_tiles_r <= perf_tiles_r;
            end
            if (busy_r) begin
                perf_busy_r <= sat_inc32(perf_busy_r);
            end else begin
                perf_busy_r <= perf_busy_r;
            end
        end
    end

    assign perf_tiles       = perf_tiles_r;
    assign perf_busy_cycles = perf_busy_r;
`else
    logic unused_handshake_s;
    assign unused_handshake_s = handshake_s;
    assign perf_tiles         = 32'd0;
    assign perf_busy_cycles   = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_controller.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_controller
// Drives tile commands (directed and $urandom) into a small-geometry
// controller, emulates the two operand buffers, and compares every output
// against the timeline computed from the command: accept cycle T, reads in
// T+1..T+K, sa_en in T+2..T+K+1, result one cycle after compute_done.
// -----------------------------------------------------------------------------
module tb_systolic_tile_controller;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IPW  = 8;
    localparam int KW   = 16;
    localparam int AW   = 16;

`ifdef SYSTOLIC_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_valid = 1'b0;
    logic                start_ready;
    logic [KW-1:0]       start_k = '0;
    logic [AW-1:0]       start_a_base = '0;
    logic [AW-1:0]       start_w_base = '0;
    logic                a_rd_en;
    logic [AW-1:0]       a_rd_addr;
    logic [ROWS*IPW-1:0] a_rd_data = '0;
    logic                w_rd_en;
    logic [AW-1:0]       w_rd_addr;
    logic [COLS*IPW-1:0] w_rd_data = '0;
    logic                sa_en;
    logic                sa_clr;
    logic [ROWS*IPW-1:0] sa_input_matrix;
    logic [COLS*IPW-1:0] sa_weight_matrix;
    logic                sa_compute_done = 1'b0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic                busy;
    logic                err_zero_k;
    logic [31:0]         perf_tiles;
    logic [31:0]         perf_busy_cycles;

    int     total = 0;
    int     bad   = 0;
    longint exp_tiles = 0;
    longint exp_busy  = 0;
    logic [15:0] salt_a;
    logic [15:0] salt_w;

    always #5 clk = ~clk;

    systolic_tile_controller #(
        .rows(ROWS), .cols(COLS), .ip_width(IPW), .k_width(KW), .addr_width(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_k(start_k),
        .start_a_base(start_a_base), .start_w_base(start_w_base),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .sa_en(sa_en), .sa_clr(sa_clr),
        .sa_input_matrix(sa_input_matrix), .sa_weight_matrix(sa_weight_matrix),
        .sa_compute_done(sa_compute_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .err_zero_k(err_zero_k),
        .perf_tiles(perf_tiles), .perf_busy_cycles(perf_busy_cycles)
    );

    // Buffer contents: a fixed function of address, salted per run.
    function automatic logic [31:0] a_mem(input logic [15:0] addr);
        return {addr ^ salt_a, addr};
    endfunction

    function automatic logic [31:0] w_mem(input logic [15:0] addr);
        return {addr, ~addr ^ salt_w};
    endfunction

    // Operand buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem(a_rd_addr);
        if (w_rd_en) w_rd_data <= w_mem(w_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, "_tiles"}, perf_tiles, PERF_ON ? exp_tiles : 64'd0);
        chk({tag, "_busy"},  perf_busy_cycles, PERF_ON ? exp_busy : 64'd0);
    endtask

    // One full tile. dd: WAIT cycles before compute_done; rd: RESULT cycles
    // with res_ready low; poke: pulse start_valid while the result is pending;
    // bg: res_ready level while not in the result phase.
    task automatic run_tile(input int k, input logic [15:0] ab, input logic [15:0] wb,
                            input int dd, input int rd, input bit poke, input bit bg);
        chk("idle_ready", start_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk_perf("idle_perf");
        res_ready    = bg;
        start_valid  = 1'b1;
        start_k      = KW'(k);
        start_a_base = ab;
        start_w_base = wb;
        step();
        start_valid  = 1'b0;
        start_k      = KW'($urandom_range(0, 255));
        start_a_base = AW'($urandom);
        start_w_base = AW'($urandom);
        for (int j = 1; j <= k + 1; j++) begin
            chk("a_rd_en", a_rd_en, j <= k);
            chk("w_rd_en", w_rd_en, j <= k);
            if (j <= k) begin
                chk("a_addr", a_rd_addr, 16'(ab + j - 1));
                chk("w_addr", w_rd_addr, 16'(wb + j - 1));
            end
            chk("sa_en", sa_en, j >= 2);
            chk("sa_clr", sa_clr, j == 2);
            if (j >= 2) begin
                chk("a_oper", sa_input_matrix, a_mem(16'(ab + j - 2)));
                chk("w_oper", sa_weight_matrix, w_mem(16'(wb + j - 2)));
            end else begin
                chk("a_oper0", sa_input_matrix, 32'd0);
                chk("w_oper0", sa_weight_matrix, 32'd0);
            end
            chk("str_busy", busy, 1'b1);
            chk("str_ready", start_ready, 1'b0);
            chk("str_valid", res_valid, 1'b0);
            step();
        end
        for (int d = 0; d <= dd; d++) begin
            chk("wait_sa_en", sa_en, 1'b0);
            chk("wait_rd_en", a_rd_en, 1'b0);
            chk("wait_valid", res_valid, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_oper", sa_input_matrix, 32'd0);
            if (d == dd) sa_compute_done = 1'b1;
            step();
        end
        res_ready = 1'b0;
        for (int r = 0; r < rd; r++) begin
            chk("res_hold", res_valid, 1'b1);
            chk("res_ready_lo", start_ready, 1'b0);
            chk("res_busy", busy, 1'b1);
            chk("res_sa_en", sa_en, 1'b0);
            start_valid = poke && (r == 1);
            start_k     = 16'd2;
            step();
        end
        start_valid = 1'b0;
        chk("res_valid", res_valid, 1'b1);
        res_ready = 1'b1;
        step();
        res_ready       = 1'b0;
        sa_compute_done = 1'b0;
        exp_tiles++;
        exp_busy += (k + 1) + (dd + 1) + (rd + 1);
        chk("done_valid", res_valid, 1'b0);
        chk("done_ready", start_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_rd_en", a_rd_en, 1'b0);
    endtask

    task automatic zero_k();
        chk("zk_ready0", start_ready, 1'b1);
        start_valid = 1'b1;
        start_k     = 16'd0;
        step();
        start_valid = 1'b0;
        chk("zk_err", err_zero_k, 1'b1);
        chk("zk_rd_en", a_rd_en, 1'b0);
        chk("zk_sa_en", sa_en, 1'b0);
        chk("zk_valid", res_valid, 1'b0);
        chk("zk_busy", busy, 1'b0);
        chk("zk_ready", start_ready, 1'b1);
        step();
        chk("zk_err_once", err_zero_k, 1'b0);
        chk("zk_rd_en2", a_rd_en, 1'b0);
        chk("zk_sa_en2", sa_en, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, start_ready, 1'b1);
        chk({tag, "_rd_en"}, a_rd_en, 1'b0);
        chk({tag, "_w_rd_en"}, w_rd_en, 1'b0);
        chk({tag, "_a_addr"}, a_rd_addr, 16'd0);
        chk({tag, "_w_addr"}, w_rd_addr, 16'd0);
        chk({tag, "_sa_en"}, sa_en, 1'b0);
        chk({tag, "_sa_clr"}, sa_clr, 1'b0);
        chk({tag, "_oper"}, sa_input_matrix, 32'd0);
        chk({tag, "_valid"}, res_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err_zero_k, 1'b0);
        chk({tag, "_ptiles"}, perf_tiles, 32'd0);
        chk({tag, "_pbusy"}, perf_busy_cycles, 32'd0);
    endtask

    initial begin
        salt_a = 16'($urandom);
        salt_w = 16'($urandom);

        rst = 1'b1;
        step();
        step();
        chk_reset_state("rst");
        rst = 1'b0;
        step();

        // Directed tiles.
        run_tile(4, 16'h0010, 16'h0020, 9, 0, 1'b0, 1'b1);
        zero_k();
        run_tile(4, 16'hFFFE, 16'hFFFF, 2, 1, 1'b0, 1'b0);
        run_tile(3, 16'h1234, 16'hABCD, 0, 10, 1'b1, 1'b0);
        run_tile(3, 16'h0000, 16'h8000, 5, 2, 1'b0, 1'b1);
        run_tile(1, 16'hFFFF, 16'h0001, 0, 0, 1'b0, 1'b1);
        chk_perf("perf_mid");

        // Randomised tiles.
        for (int t = 0; t < 10; t++) begin
            run_tile($urandom_range(1, 9), 16'($urandom), 16'($urandom),
                     $urandom_range(0, 12), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a K=8 stream, at beat 2.
        start_valid  = 1'b1;
        start_k      = 16'd8;
        start_a_base = 16'h0100;
        start_w_base = 16'h0200;
        step();
        start_valid = 1'b0;
        step();
        step();
        chk("mid_addr", a_rd_addr, 16'h0102);
        chk("mid_rd_en", a_rd_en, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("midrst");
        exp_tiles = 0;
        exp_busy  = 0;

        // Two K=3 tiles after reset for the counters.
        run_tile(3, 16'h0040, 16'h0050, 3, 0, 1'b0, 1'b1);
        run_tile(3, 16'h0060, 16'h0070, 1, 2, 1'b0, 1'b0);
        chk_perf("perf_end");
        step();
        chk_perf("perf_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
